// File: rtl/wb_arbiter_pkg.sv
// Shared types for the write-back arbiter: register address, write request and queued LSU entry.
package wb_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_X0 = 5'd0;

    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // live is cleared when a younger ALU write to the same rd overtakes the entry
    typedef struct packed {
        logic    live;
        wb_req_t req;
    } wb_entry_t;

    function automatic logic waw_hit(input logic en, input reg_addr_t kill_rd, input reg_addr_t rd);
        return en && (kill_rd == rd);
    endfunction

    function automatic logic fwd_match(input logic we, input reg_addr_t wr_addr, input reg_addr_t rd_addr);
        return we && (wr_addr == rd_addr) && (rd_addr != REG_X0);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the ALU/LSU producer inputs, regfile write port and bypass signals around wb_arbiter.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN = wb_arbiter_pkg::XLEN
);

    logic            alu_valid;
    reg_addr_t       alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    reg_addr_t       lsu_rd;
    logic [XLEN-1:0] lsu_data;

    logic            we3;
    reg_addr_t       a3;
    logic [XLEN-1:0] wd3;

    reg_addr_t       fwd_a1;
    reg_addr_t       fwd_a2;
    logic            fwd_hit1;
    logic            fwd_hit2;
    logic [XLEN-1:0] fwd_data1;
    logic [XLEN-1:0] fwd_data2;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        input  we3, a3, wd3,
        output fwd_a1, fwd_a2,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        output we3, a3, wd3,
        input  fwd_a1, fwd_a2,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Small synchronous FIFO holding LSU results that lost the write port, with a per-entry WAW kill.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_req_t   push_req,
    input  logic      pop,
    input  logic      kill_en,
    input  reg_addr_t kill_rd,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] live;
    wb_req_t          mem [DEPTH];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = '{live: live[rd_ptr], req: mem[rd_ptr]};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waw_hit(kill_en, kill_rd, mem[i].rd)) begin
                    live[i] <= 1'b0;
                end
            end
            if (push) begin
                live[wr_ptr] <= !waw_hit(kill_en, kill_rd, push_req.rd);
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU beats win the regfile write port, LSU beats cut through or queue,
// and the committed write is bypassed to both read ports.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int LSU_DEPTH = 2,
    parameter int XLEN      = wb_arbiter_pkg::XLEN
) (
    input logic         clk,
    input logic         rst_n,
    wb_arbiter_if.slave bus
);

    logic      alu_issue;
    logic      fifo_push;
    logic      fifo_pop;
    logic      fifo_full;
    logic      fifo_empty;
    logic      cut_through;
    wb_entry_t fifo_head;

    logic            vld_p0;
    wb_req_t         req_p0;
    logic            vld_p1;
    reg_addr_t       rd_p1;
    logic [XLEN-1:0] data_p1;

    wb_fifo #(
        .DEPTH (LSU_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_req ('{rd: bus.lsu_rd, data: bus.lsu_data}),
        .pop      (fifo_pop),
        .kill_en  (alu_issue),
        .kill_rd  (bus.alu_rd),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    // Full blocks acceptance even when a pop frees a slot this cycle
    assign bus.lsu_ready = !fifo_full;

    always_comb begin
        alu_issue   = bus.alu_valid && (bus.alu_rd != REG_X0);
        fifo_pop    = !alu_issue && !fifo_empty;
        cut_through = !alu_issue && fifo_empty && bus.lsu_valid && (bus.lsu_rd != REG_X0);
        fifo_push   = bus.lsu_valid && !fifo_full && (bus.lsu_rd != REG_X0) && !cut_through;

        vld_p0 = 1'b0;
        req_p0 = '{rd: bus.alu_rd, data: bus.alu_data};
        if (alu_issue) begin
            vld_p0 = 1'b1;
        end else if (fifo_pop) begin
            vld_p0 = fifo_head.live;
            req_p0 = fifo_head.req;
        end else if (cut_through) begin
            vld_p0 = 1'b1;
            req_p0 = '{rd: bus.lsu_rd, data: bus.lsu_data};
        end
    end

    // p0 -> p1: regfile write register; address/data hold when nothing is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            rd_p1   <= REG_X0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                rd_p1   <= req_p0.rd;
                data_p1 <= req_p0.data;
            end
        end
    end

    assign bus.we3 = vld_p1;
    assign bus.a3  = rd_p1;
    assign bus.wd3 = data_p1;

    assign bus.fwd_hit1  = fwd_match(vld_p1, rd_p1, bus.fwd_a1);
    assign bus.fwd_hit2  = fwd_match(vld_p1, rd_p1, bus.fwd_a2);
    assign bus.fwd_data1 = bus.fwd_hit1 ? data_p1 : '0;
    assign bus.fwd_data2 = bus.fwd_hit2 ? data_p1 : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter plus hand-written wrap and mid-traffic reset sequences.
module tb_wb_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    wb_arbiter_if bus ();

    wb_arbiter #(
        .LSU_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic [4:0]  fa1;
        logic [4:0]  fa2;
        logic        rdy;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [31:0] adata,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
        input logic [4:0] fa1, input logic [4:0] fa2,
        input logic rdy, input logic we, input logic [4:0] a3, input logic [31:0] wd,
        input logic h1, input logic [31:0] d1, input logic h2, input logic [31:0] d2);
        vec_t v;
        v.av = av;   v.ard = ard; v.adata = adata;
        v.lv = lv;   v.lrd = lrd; v.ldata = ldata;
        v.fa1 = fa1; v.fa2 = fa2;
        v.rdy = rdy; v.we = we;   v.a3 = a3; v.wd = wd;
        v.h1 = h1;   v.d1 = d1;   v.h2 = h2; v.d2 = d2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = adata;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ldata;
    endtask

    task automatic check_write(input string tag, input logic we, input logic [4:0] a3, input logic [31:0] wd);
        check({tag, ".we3"}, 32'(bus.we3), 32'(we));
        check({tag, ".a3"},  32'(bus.a3),  32'(a3));
        check({tag, ".wd3"}, bus.wd3,      wd);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        drive(v.av, v.ard, v.adata, v.lv, v.lrd, v.ldata);
        bus.fwd_a1 = v.fa1;
        bus.fwd_a2 = v.fa2;
        #1;
        check({tag, ".lsu_ready"}, 32'(bus.lsu_ready), 32'(v.rdy));
        @(posedge clk);
        #1;
        check_write(tag, v.we, v.a3, v.wd);
        check({tag, ".fwd_hit1"},  32'(bus.fwd_hit1), 32'(v.h1));
        check({tag, ".fwd_data1"}, bus.fwd_data1,     v.d1);
        check({tag, ".fwd_hit2"},  32'(bus.fwd_hit2), 32'(v.h2));
        check({tag, ".fwd_data2"}, bus.fwd_data2,     v.d2);
    endtask

    initial begin
        errors = 0;
        checks = 0;

        //            av ard   adata         lv lrd   ldata         fa1   fa2   rdy we a3     wd            h1 d1            h2 d2
        vecs[0]  = mk(1, 5'd5, 32'h1234,     0, 5'd0, 32'h0,        5'd5, 5'd0, 1, 1, 5'd5,  32'h1234,     1, 32'h1234,     0, 32'h0);
        vecs[1]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd5, 5'd5, 1, 0, 5'd5,  32'h1234,     0, 32'h0,        0, 32'h0);
        vecs[2]  = mk(1, 5'd1, 32'h11,       1, 5'd7, 32'hA,        5'd1, 5'd7, 1, 1, 5'd1,  32'h11,       1, 32'h11,       0, 32'h0);
        vecs[3]  = mk(1, 5'd2, 32'h22,       1, 5'd8, 32'hB,        5'd0, 5'd2, 1, 1, 5'd2,  32'h22,       0, 32'h0,        1, 32'h22);
        vecs[4]  = mk(1, 5'd3, 32'h33,       1, 5'd10, 32'hC,       5'd3, 5'd3, 0, 1, 5'd3,  32'h33,       1, 32'h33,       1, 32'h33);
        vecs[5]  = mk(0, 5'd0, 32'h0,        1, 5'd10, 32'hC,       5'd7, 5'd8, 0, 1, 5'd7,  32'hA,        1, 32'hA,        0, 32'h0);
        vecs[6]  = mk(0, 5'd0, 32'h0,        1, 5'd10, 32'hC,       5'd8, 5'd7, 1, 1, 5'd8,  32'hB,        1, 32'hB,        0, 32'h0);
        vecs[7]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd10, 5'd10, 1, 1, 5'd10, 32'hC,      1, 32'hC,        1, 32'hC);
        vecs[8]  = mk(1, 5'd4, 32'h44,       1, 5'd9, 32'h1,        5'd9, 5'd4, 1, 1, 5'd4,  32'h44,       0, 32'h0,        1, 32'h44);
        vecs[9]  = mk(1, 5'd9, 32'h2,        0, 5'd0, 32'h0,        5'd9, 5'd0, 1, 1, 5'd9,  32'h2,        1, 32'h2,        0, 32'h0);
        vecs[10] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd9, 5'd9, 1, 0, 5'd9,  32'h2,        0, 32'h0,        0, 32'h0);
        vecs[11] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd9, 5'd9, 1, 0, 5'd9,  32'h2,        0, 32'h0,        0, 32'h0);
        vecs[12] = mk(1, 5'd11, 32'h5,       1, 5'd11, 32'h6,       5'd11, 5'd0, 1, 1, 5'd11, 32'h5,       1, 32'h5,        0, 32'h0);
        vecs[13] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd11, 5'd11, 1, 0, 5'd11, 32'h5,      0, 32'h0,        0, 32'h0);
        vecs[14] = mk(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd11, 1, 0, 5'd11, 32'h5,       0, 32'h0,        0, 32'h0);
        vecs[15] = mk(1, 5'd0, 32'hFFFFFFFF, 1, 5'd12, 32'h77,      5'd0, 5'd12, 1, 1, 5'd12, 32'h77,      0, 32'h0,        1, 32'h77);
        vecs[16] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd12, 5'd12, 1, 0, 5'd12, 32'h77,     0, 32'h0,        0, 32'h0);

        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        bus.fwd_a1 = 5'd0;
        bus.fwd_a2 = 5'd0;
        rst_n = 1'b0;
        #1;
        check("reset.lsu_ready", 32'(bus.lsu_ready), 32'd1);
        check_write("reset", 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_write("post_reset", 1'b0, 5'd0, 32'h0);

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i], i);
        end

        // Wrap: one ALU beat parks an LSU beat, then each new beat pushes while the previous pops
        bus.fwd_a1 = 5'd0;
        bus.fwd_a2 = 5'd0;
        for (int i = 0; i <= 10; i++) begin
            if (i == 0) begin
                drive(1, 5'd20, 32'h99, 1, 5'd13, 32'h100);
            end else if (i < 10) begin
                drive(0, 5'd0, 32'h0, 1, 5'(13 + i), 32'h100 + 32'(i));
            end else begin
                drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
            end
            #1;
            check($sformatf("wrap%0d.lsu_ready", i), 32'(bus.lsu_ready), 32'd1);
            @(posedge clk);
            #1;
            if (i == 0) begin
                check_write("wrap0", 1'b1, 5'd20, 32'h99);
            end else begin
                check_write($sformatf("wrap%0d", i), 1'b1, 5'(13 + i - 1), 32'h100 + 32'(i - 1));
            end
        end
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        check_write("wrap_drain", 1'b0, 5'd22, 32'h109);

        // Mid-traffic reset with two LSU beats queued behind ALU writes
        drive(1, 5'd6, 32'h66, 1, 5'd14, 32'hE);
        @(posedge clk);
        #1;
        drive(1, 5'd6, 32'h67, 1, 5'd15, 32'hF);
        @(posedge clk);
        #1;
        check("midrst.full_ready", 32'(bus.lsu_ready), 32'd0);
        check_write("midrst.pre", 1'b1, 5'd6, 32'h67);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.lsu_ready", 32'(bus.lsu_ready), 32'd1);
        check_write("midrst", 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_write($sformatf("after_rst%0d", i), 1'b0, 5'd0, 32'h0);
            check($sformatf("after_rst%0d.lsu_ready", i), 32'(bus.lsu_ready), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
